// File: rtl/spi_mstr_mcs.sv
// SPI mode-0 master with NUM_SS one-hot-low slave selects and fully registered outputs.
// Define SPI_MCS_ERR_EN to add the 'err' pulse reporting an out-of-range ss_sel.
module spi_mstr_mcs #(
  parameter int NUM_SS   = 5,
  parameter int SEL_W    = 3,
  parameter int DATA_W   = 16,
  parameter int SCLK_DIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_in,
  output logic              done,
  output logic              busy,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] ss_n
`ifdef SPI_MCS_ERR_EN
  , output logic            err
`endif
);

  localparam int HALF  = SCLK_DIV / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [SEL_W:0] NumSsL = (SEL_W+1)'(NUM_SS);

  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-2:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   data_in_q, data_in_d;
  logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef SPI_MCS_ERR_EN
  logic                err_q, err_d;
`endif

  logic cntEnd;
  logic selLegal;

  assign cntEnd   = (cnt_q == CNT_W'(HALF - 1));
  assign selLegal = ({1'b0, ss_sel} < NumSsL);

  // Reset clears everything at once so an interrupted transfer never resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_in_q <= '0;
      ss_n_q    <= '1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPI_MCS_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_in_q <= data_in_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SPI_MCS_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  // A wrt coinciding with done is blocked by done_q so a new transfer starts a cycle later.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_in_d = data_in_q;
    ss_n_d    = ss_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SPI_MCS_ERR_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (wrt && !done_q) begin
          if (selLegal) begin
            state_d = FRONT;
            busy_d  = 1'b1;
            cnt_d   = '0;
            bit_d   = '0;
            mosi_d  = data_out[DATA_W-1];
            tx_d    = data_out[DATA_W-2:0];
            for (int i = 0; i < NUM_SS; i++) ss_n_d[i] = (SEL_W'(i) != ss_sel);
          end
`ifdef SPI_MCS_ERR_EN
          else begin
            err_d = 1'b1;
          end
`endif
        end
      end
      FRONT: begin
        cnt_d = cnt_q + 1'b1;
        if (cntEnd) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cntEnd) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[DATA_W-2:0], MISO};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              state_d = BACK;
            end else begin
              bit_d  = bit_q + 1'b1;
              mosi_d = tx_q[DATA_W-2];
              tx_d   = {tx_q[DATA_W-3:0], 1'b0};
            end
          end
        end
      end
      BACK: begin
        cnt_d = cnt_q + 1'b1;
        if (cntEnd) begin
          cnt_d     = '0;
          state_d   = IDLE;
          ss_n_d    = '1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          data_in_d = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_in = data_in_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign ss_n    = ss_n_q;
`ifdef SPI_MCS_ERR_EN
  assign err     = err_q;
`endif

endmodule

// File: tb/tb_spi_mstr_mcs.sv
// Directed bench for spi_mstr_mcs: a default instance (5 selects, 16 bits, div 16)
// and a small instance (8 selects, 8 bits, div 4) share clock, reset and MISO.
module tb_spi_mstr_mcs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt = 1'b0;
  logic        useB = 1'b0;
  logic [2:0]  ssSel = '0;
  logic [31:0] dataOut = '0;
  logic        miso = 1'b0;

  logic [15:0] dinA;
  logic        doneA, busyA, sclkA, mosiA;
  logic [4:0]  ssA;
  logic [7:0]  dinB;
  logic        doneB, busyB, sclkB, mosiB;
  logic [7:0]  ssB;
`ifdef SPI_MCS_ERR_EN
  logic        errA, errB;
`endif

  logic        obsSclk, obsMosi, obsDone, obsBusy;
  logic [7:0]  obsSs;
  logic [31:0] obsDataIn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_mstr_mcs dutA (
    .clk(clk), .rst_n(rst_n), .wrt(wrt && !useB), .ss_sel(ssSel),
    .data_out(dataOut[15:0]), .data_in(dinA), .done(doneA), .busy(busyA),
    .SCLK(sclkA), .MOSI(mosiA), .MISO(miso), .ss_n(ssA)
`ifdef SPI_MCS_ERR_EN
    , .err(errA)
`endif
  );

  spi_mstr_mcs #(.NUM_SS(8), .SEL_W(3), .DATA_W(8), .SCLK_DIV(4)) dutB (
    .clk(clk), .rst_n(rst_n), .wrt(wrt && useB), .ss_sel(ssSel),
    .data_out(dataOut[7:0]), .data_in(dinB), .done(doneB), .busy(busyB),
    .SCLK(sclkB), .MOSI(mosiB), .MISO(miso), .ss_n(ssB)
`ifdef SPI_MCS_ERR_EN
    , .err(errB)
`endif
  );

  assign obsSclk   = useB ? sclkB : sclkA;
  assign obsMosi   = useB ? mosiB : mosiA;
  assign obsDone   = useB ? doneB : doneA;
  assign obsBusy   = useB ? busyB : busyA;
  assign obsSs     = useB ? ssB : {3'b111, ssA};
  assign obsDataIn = useB ? {24'b0, dinB} : {16'b0, dinA};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction observed at negedges; cycle 1 is the first cycle after wrt is sampled.
  task automatic runTxn(input string tag, input logic b, input logic [2:0] sel,
                        input logic [31:0] dout, input logic [31:0] slave, input int dw,
                        input logic [7:0] expSs, input int expDone,
                        input int secondAt, input logic [2:0] sel2, input logic [31:0] data2);
    int cyc, doneAt, rises, ssBad, doneCnt;
    logic [31:0] mosiWord;
    logic prevSclk;
    useB = b;
    @(negedge clk);
    ssSel = sel; dataOut = dout; miso = slave[dw-1]; wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
    cyc = 1; doneAt = -1; rises = 0; ssBad = 0; doneCnt = 0; mosiWord = '0; prevSclk = 1'b0;
    checkOutput({tag, "-busy1"}, {31'b0, obsBusy}, 32'd1);
    checkOutput({tag, "-mosi1"}, {31'b0, obsMosi}, {31'b0, dout[dw-1]});
    while (cyc < expDone + 20) begin
      if (obsSclk && !prevSclk) begin
        mosiWord = {mosiWord[30:0], obsMosi};
        rises++;
        if (rises < dw) miso = slave[dw-1-rises];
      end
      prevSclk = obsSclk;
      if (obsDone) begin
        doneCnt++;
        if (doneAt < 0) doneAt = cyc;
      end
      if (doneAt < 0 && obsSs !== expSs) ssBad++;
      if (cyc == secondAt) begin
        ssSel = sel2; dataOut = data2; wrt = 1'b1;
      end else begin
        wrt = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "-ssDuring"}, ssBad, 0);
    checkOutput({tag, "-rises"}, rises, dw);
    checkOutput({tag, "-mosiWord"}, mosiWord, dout);
    checkOutput({tag, "-doneCycle"}, doneAt, expDone);
    checkOutput({tag, "-doneCount"}, doneCnt, 1);
    checkOutput({tag, "-dataIn"}, obsDataIn, slave);
    checkOutput({tag, "-ssIdle"}, {24'b0, obsSs}, 32'hFF);
    checkOutput({tag, "-busyIdle"}, {31'b0, obsBusy}, 32'd0);
  endtask

  task automatic applyStimulus();
    int sawSs, sawSclk, sawDone, sawBusy;
    repeat (3) @(negedge clk);
    checkOutput("rst-ss", {27'b0, ssA}, 32'h1F);
    checkOutput("rst-sclk", {31'b0, sclkA}, 32'd0);
    checkOutput("rst-mosi", {31'b0, mosiA}, 32'd0);
    checkOutput("rst-busy", {31'b0, busyA}, 32'd0);
    checkOutput("rst-done", {31'b0, doneA}, 32'd0);
    checkOutput("rst-dataIn", {16'b0, dinA}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    runTxn("basic", 1'b0, 3'd1, 32'h13DD, 32'hA55A, 16, 8'b11111101, 273, -1, 3'd0, 32'h0);
    runTxn("ignore2nd", 1'b0, 3'd4, 32'h00EF, 32'h1234, 16, 8'b11101111, 273, 50, 3'd0, 32'hBEEF);

    // Out-of-range select: nothing on the bus, data_in keeps its last value.
    useB = 1'b0;
    @(negedge clk);
    ssSel = 3'd6; dataOut = 32'h5555; wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
`ifdef SPI_MCS_ERR_EN
    checkOutput("illegal-err1", {31'b0, errA}, 32'd1);
    @(negedge clk);
    checkOutput("illegal-err2", {31'b0, errA}, 32'd0);
`endif
    sawSs = 0; sawSclk = 0; sawDone = 0; sawBusy = 0;
    for (int i = 0; i < 300; i++) begin
      if (ssA !== 5'b11111) sawSs++;
      if (sclkA) sawSclk++;
      if (doneA) sawDone++;
      if (busyA) sawBusy++;
      @(negedge clk);
    end
    checkOutput("illegal-ss", sawSs, 0);
    checkOutput("illegal-sclk", sawSclk, 0);
    checkOutput("illegal-done", sawDone, 0);
    checkOutput("illegal-busy", sawBusy, 0);
    checkOutput("hold-dataIn", {16'b0, dinA}, 32'h1234);

    // Asynchronous reset 100 cycles into a transfer.
    @(negedge clk);
    ssSel = 3'd3; dataOut = 32'hFFFF; wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst-ss", {27'b0, ssA}, 32'h1F);
    checkOutput("midrst-sclk", {31'b0, sclkA}, 32'd0);
    checkOutput("midrst-busy", {31'b0, busyA}, 32'd0);
    checkOutput("midrst-dataIn", {16'b0, dinA}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runTxn("afterRst", 1'b0, 3'd2, 32'h8001, 32'h0F0F, 16, 8'b11111011, 273, -1, 3'd0, 32'h0);

    runTxn("small", 1'b1, 3'd7, 32'hC3, 32'hFF, 8, 8'h7F, 37, -1, 3'd0, 32'h0);
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
